// File: rtl/video_in_dma_writer.sv
// Captures one frame of 8-bit pixels, packs them 4 per word into a small FIFO and
// writes the words to memory as a classic single-cycle Wishbone master.
module video_in_dma_writer #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        p_clk,
  input  logic        p_resetn,
  input  logic [31:0] cfg_base_addr,
  input  logic [31:0] cfg_start,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  input  logic        pix_sof,
  output logic [31:0] p_wb_ADR_O,
  output logic [31:0] p_wb_DAT_O,
  input  logic [31:0] p_wb_DAT_I,
  output logic [3:0]  p_wb_SEL_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_STB_O,
  output logic        p_wb_WE_O,
  input  logic        p_wb_ACK_I,
  input  logic        p_wb_ERR_I,
  input  logic        p_wb_RTY_I,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        bus_err
);

  localparam int N_PIX = WIDTH * HEIGHT;
  localparam int PW    = $clog2(N_PIX + 1);
  localparam int AW    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN, S_FIN} state_t;

  state_t         state;
  logic [31:0]    base;
  logic [PW-1:0]  pix_cnt;
  logic [29:0]    word_idx;
  logic [23:0]    pack;
  logic           pend_vld;
  logic [31:0]    pend_addr;
  logic [31:0]    pend_data;
  logic [63:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           cyc;
  logic [31:0]    adr;
  logic [31:0]    dat;

  logic           start;
  logic           take;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic [4:0]     lane_lsb;
  logic           unused_dat;

  assign start    = (state == S_IDLE) && (cfg_start != 32'd0);
  assign take     = pix_valid && (((state == S_ARMED) && pix_sof) || (state == S_CAPTURE));
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // Full is the registered occupancy, so a pop in the same cycle cannot make room.
  assign push     = pend_vld && !full;
  assign pop      = cyc && (p_wb_ERR_I || (!p_wb_RTY_I && p_wb_ACK_I));
  assign lane_lsb = {pix_cnt[1:0], 3'b000};
  assign unused_dat = ^p_wb_DAT_I;

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update together from pre-edge values, regardless of statement order.
  always_ff @(posedge p_clk) begin
    if (!p_resetn) begin
      state     <= S_IDLE;
      base      <= '0;
      pix_cnt   <= '0;
      word_idx  <= '0;
      pack      <= '0;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done     <= 1'b0;
      pend_vld <= 1'b0;
      if (pend_vld && full) overflow <= 1'b1;
      case (state)
        S_IDLE: if (start) begin
          base     <= {cfg_base_addr[31:2], 2'b00};
          pix_cnt  <= '0;
          word_idx <= '0;
          overflow <= 1'b0;
          busy     <= 1'b1;
          state    <= S_ARMED;
        end
        S_ARMED, S_CAPTURE: if (take) begin
          pix_cnt <= pix_cnt + 1'b1;
          if (pix_cnt[1:0] == 2'd3) begin
            pend_vld  <= 1'b1;
            pend_data <= {pix_data, pack};
            pend_addr <= base + {word_idx, 2'b00};
            word_idx  <= word_idx + 1'b1;
          end else begin
            pack[lane_lsb +: 8] <= pix_data;
          end
          state <= (pix_cnt == PW'(N_PIX - 1)) ? S_DRAIN : S_CAPTURE;
        end
        S_DRAIN: if (empty && !cyc && !pend_vld) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_FIN;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; only the pointers and
  // count need a defined value, and leaving the array alone lets it map to RAM.
  always_ff @(posedge p_clk) begin
    if (push) mem[wr_ptr] <= {pend_addr, pend_data};
  end

  always_ff @(posedge p_clk) begin
    if (!p_resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      cyc     <= 1'b0;
      adr     <= '0;
      dat     <= '0;
      bus_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (start) bus_err <= 1'b0;
      // Any termination drops the cycle; the idle cycle that follows is the
      // mandatory gap before the next (or retried) transfer.
      if (cyc) begin
        if (p_wb_ERR_I || p_wb_RTY_I || p_wb_ACK_I) cyc <= 1'b0;
        if (p_wb_ERR_I) bus_err <= 1'b1;
      end else if (!empty) begin
        cyc <= 1'b1;
        adr <= mem[rd_ptr][63:32];
        dat <= mem[rd_ptr][31:0];
      end
    end
  end

  assign p_wb_ADR_O = adr;
  assign p_wb_DAT_O = dat;
  assign p_wb_CYC_O = cyc;
  assign p_wb_STB_O = cyc;
  assign p_wb_WE_O  = cyc;
  assign p_wb_SEL_O = {4{cyc}};

endmodule

// File: tb/tb_video_in_dma_writer.sv
// Scoreboard bench: frames are turned into expected {addr,data} writes up front,
// and a slave-side monitor compares every terminated Wishbone transfer.
module tb_video_in_dma_writer;

  localparam int W       = 8;
  localparam int H       = 10;
  localparam int D       = 16;
  localparam int N_PIX   = W * H;
  localparam int N_WORDS = N_PIX / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cfg_base_addr = '0;
  logic [31:0] cfg_start = '0;
  logic [7:0]  pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_cyc, wb_stb, wb_we;
  logic        wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0;
  logic        busy, done, overflow, bus_err;

  video_in_dma_writer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .p_clk(clk), .p_resetn(rst_n),
    .cfg_base_addr(cfg_base_addr), .cfg_start(cfg_start),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .p_wb_ADR_O(wb_adr), .p_wb_DAT_O(wb_dat), .p_wb_DAT_I(32'hDEAD_BEEF),
    .p_wb_SEL_O(wb_sel), .p_wb_CYC_O(wb_cyc), .p_wb_STB_O(wb_stb), .p_wb_WE_O(wb_we),
    .p_wb_ACK_I(wb_ack), .p_wb_ERR_I(wb_err), .p_wb_RTY_I(wb_rty),
    .busy(busy), .done(done), .overflow(overflow), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  px[N_PIX];
  int          n_cmp = 0;
  int          n_fail = 0;

  // Slave behaviour knobs, set by the main sequence.
  bit          stall = 1'b0;
  bit          rnd_wait = 1'b0;
  bit          rty_armed = 1'b0;
  bit          err_armed = 1'b0;
  logic [31:0] rty_addr = '0;
  logic [31:0] err_addr = '0;
  bit          gap_pending = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Slave + monitor: decide the response on the falling edge so the DUT sees it
  // at the next rising edge, and compare whatever transfer it terminates.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
      if (gap_pending) begin
        check("wb_gap_stb", {63'd0, wb_stb}, 64'd0);
        gap_pending = 1'b0;
      end else if (wb_stb && rst_n) begin
        if (!(stall || (rnd_wait && $urandom_range(0, 2) == 0))) begin
          check("wb_ctrl", {wb_cyc, wb_we, wb_sel}, {1'b1, 1'b1, 4'hF});
          if (exp_q.size() == 0) begin
            check("wb_unexpected_write", {wb_adr, wb_dat}, 64'd0);
          end else begin
            e = exp_q[0];
            check("wb_addr", {32'd0, wb_adr}, {32'd0, e.addr});
            check("wb_data", {32'd0, wb_dat}, {32'd0, e.data});
          end
          if (err_armed && wb_adr == err_addr) begin
            wb_err = 1'b1; wb_ack = 1'($urandom_range(0, 1)); err_armed = 1'b0;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end else if (rty_armed && wb_adr == rty_addr) begin
            wb_rty = 1'b1; wb_ack = 1'($urandom_range(0, 1)); rty_armed = 1'b0;
          end else begin
            wb_ack = 1'b1;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end
          gap_pending = 1'b1;
        end
      end
    end
  end

  // Builds the frame, queues the writes it must produce (the first `keep` words)
  // and issues a start pulse with a random nonzero command value.
  task automatic start_frame(input logic [31:0] base_in, input bit seq, input int keep);
    logic [31:0] b;
    b = base_in & 32'hFFFF_FFFC;
    for (int i = 0; i < N_PIX; i++) px[i] = seq ? 8'(i) : 8'($urandom);
    for (int w = 0; w < keep; w++)
      exp_q.push_back('{addr: b + 32'(4 * w),
                        data: {px[4*w+3], px[4*w+2], px[4*w+1], px[4*w]}});
    @(posedge clk); #1;
    cfg_base_addr = base_in;
    cfg_start     = $urandom | 32'h1;
    @(posedge clk); #1;
    cfg_start     = '0;
    cfg_base_addr = 32'h1234_5678;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("flags_cleared_by_start", {62'd0, overflow, bus_err}, 64'd0);
  endtask

  task automatic drive_pixels(input int n, input bit gaps, input bit pre_junk, input bit noise);
    int i;
    if (pre_junk) begin
      for (int k = 0; k < 3; k++) begin
        pix_valid = 1'b1; pix_data = 8'h55; pix_sof = 1'b0;
        @(posedge clk); #1;
      end
      pix_valid = 1'b0; pix_data = 8'h55; pix_sof = 1'b1;
      @(posedge clk); #1;
    end
    i = 0;
    while (i < n) begin
      cfg_start = (noise && i == 9) ? 32'h4 : 32'h0;
      if (!gaps || $urandom_range(0, 3) != 0) begin
        pix_valid = 1'b1;
        pix_data  = px[i];
        pix_sof   = (i == 0) || (noise && $urandom_range(0, 7) == 0);
        i++;
      end else begin
        pix_valid = 1'b0;
        pix_data  = 8'($urandom);
        pix_sof   = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    cfg_start = '0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic wait_done(input bit exp_ovf, input bit exp_err);
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("overflow_flag", {63'd0, overflow}, {63'd0, exp_ovf});
    check("bus_err_flag", {63'd0, bus_err}, {63'd0, exp_err});
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_bus", {wb_cyc, wb_stb, wb_we, wb_sel, wb_adr}, 64'd0);
    check("reset_status", {60'd0, busy, done, overflow, bus_err}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Sequential frame, zero-wait slave.
    start_frame(32'hA000_0000, 1'b1, N_WORDS);
    drive_pixels(N_PIX, 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, 1'b0);

    // 0x55 pixels while armed must not be captured.
    start_frame(32'hA000_0000, 1'b1, N_WORDS);
    drive_pixels(N_PIX, 1'b0, 1'b1, 1'b0);
    wait_done(1'b0, 1'b0);

    // Slave stalls while all 20 words are produced: words 16..19 are dropped.
    stall = 1'b1;
    start_frame(32'hA000_0000, 1'b0, D);
    drive_pixels(N_PIX, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_done(1'b1, 1'b0);

    // Retry on the first attempt at base+4.
    rty_addr = 32'hA000_0004; rty_armed = 1'b1;
    start_frame(32'hA000_0000, 1'b1, N_WORDS);
    drive_pixels(N_PIX, 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, 1'b0);
    check("rty_issued", {63'd0, rty_armed}, 64'd0);

    // Error on base+8: the word is lost, the rest still written.
    err_addr = 32'hA000_0008; err_armed = 1'b1;
    start_frame(32'hA000_0000, 1'b1, N_WORDS);
    drive_pixels(N_PIX, 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, 1'b1);
    check("err_issued", {63'd0, err_armed}, 64'd0);

    // Random pixels, gaps, stray sof/start, random slave waits, address wrap.
    rnd_wait = 1'b1;
    start_frame(32'hFFFF_FFE7, 1'b0, N_WORDS);
    drive_pixels(N_PIX, 1'b1, 1'b1, 1'b1);
    wait_done(1'b0, 1'b0);
    for (int f = 0; f < 2; f++) begin
      start_frame($urandom, 1'b0, N_WORDS);
      drive_pixels(N_PIX, 1'b1, 1'b0, 1'b1);
      wait_done(1'b0, 1'b0);
    end
    rnd_wait = 1'b0;

    // Reset while a transfer is held on the bus.
    stall = 1'b1;
    start_frame(32'hA000_0000, 1'b0, 0);
    drive_pixels(20, 1'b0, 1'b0, 1'b0);
    t = 0;
    while (!wb_stb && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("stb_before_reset", {63'd0, wb_stb}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("reset_drops_bus", {61'd0, wb_cyc, wb_stb, busy}, 64'd0);
    stall = 1'b0;
    exp_q.delete();
    start_frame(32'hA000_0100, 1'b0, N_WORDS);
    drive_pixels(N_PIX, 1'b1, 1'b0, 1'b0);
    wait_done(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
